// File: rtl/pe_feeder_pkg.sv
// rtl/pe_feeder_pkg.sv - shared widths and FSM state type for the PE stream feeder
package pe_feeder_pkg;

  localparam int W_W        = 4;
  localparam int ACT_W      = 8;
  localparam int RES_W      = 21;
  localparam int BIN_CNT    = 8;
  localparam int DRAIN_WAIT = BIN_CNT - 1;

  typedef enum logic [2:0] {
    CLEAR,
    STREAM,
    ACC,
    DRAIN,
    CAPTURE
  } feeder_state_t;

endpackage

// File: rtl/pe_result_slot.sv
// rtl/pe_result_slot.sv - one-entry valid/ready output register holding a PE result and beat count
module pe_result_slot
  import pe_feeder_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic signed [RES_W-1:0] data_i,
  input  logic [CNT_W-1:0]        count_i,
  input  logic                    out_ready_i,
  output logic                    free_o,
  output logic                    out_valid_o,
  output logic signed [RES_W-1:0] out_data_o,
  output logic [CNT_W-1:0]        out_count_o
);

  logic                    valid_q;
  logic signed [RES_W-1:0] data_q;
  logic [CNT_W-1:0]        count_q;

  // Loads are only issued while free, so a load never overwrites an untaken entry.
  assign free_o = !valid_q || out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_count_o = count_q;

endmodule

// File: rtl/pe_stream_feeder.sv
// rtl/pe_stream_feeder.sv - sequences one MAC PE through clear, stream, accumulate-drain and capture
module pe_stream_feeder
  import pe_feeder_pkg::*;
#(
  parameter int VEC_LEN = 64,
  parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_W-1:0]   in_weight,
  input  logic signed [ACT_W-1:0] in_act,
  input  logic                    in_last,
  output logic                    pe_en,
  output logic                    pe_data_valid,
  output logic signed [W_W-1:0]   pe_weight,
  output logic signed [ACT_W-1:0] pe_act,
  output logic                    pe_acc,
  output logic                    pe_reset,
  input  logic                    pe_output_valid,
  input  logic signed [RES_W-1:0] pe_output_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [RES_W-1:0] out_data,
  output logic [CNT_W-1:0]        out_count
);

  feeder_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       drain_q;
  logic             in_ready_q;
  logic             pe_reset_q;
  logic             pe_acc_q;
  logic             pe_en_q;
  logic             accept;
  logic             beat_final;
  logic             slot_free;
  logic             slot_load;

  assign accept     = in_ready_q && in_valid;
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign beat_final = in_last || (cnt_d == CNT_W'(VEC_LEN));
  assign slot_load  = (state_q == CAPTURE) && pe_output_valid && slot_free;

  // Control pins are registered; only the data path is a gated pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      drain_q    <= '0;
      in_ready_q <= 1'b0;
      pe_reset_q <= 1'b1;
      pe_acc_q   <= 1'b0;
      pe_en_q    <= 1'b0;
    end else begin
      pe_en_q <= 1'b1;
      case (state_q)
        CLEAR: begin
          cnt_q      <= '0;
          pe_reset_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= STREAM;
        end
        STREAM: begin
          if (accept) begin
            cnt_q <= cnt_d;
            if (beat_final) begin
              in_ready_q <= 1'b0;
              pe_acc_q   <= 1'b1;
              state_q    <= ACC;
            end
          end
        end
        ACC: begin
          pe_acc_q <= 1'b0;
          drain_q  <= 3'(DRAIN_WAIT);
          state_q  <= DRAIN;
        end
        DRAIN: begin
          if (drain_q == 3'd1) begin
            state_q <= CAPTURE;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        CAPTURE: begin
          // Hold here without clearing the PE until the output slot can take the result.
          if (slot_load) begin
            pe_reset_q <= 1'b1;
            state_q    <= CLEAR;
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          pe_acc_q   <= 1'b0;
          pe_reset_q <= 1'b1;
          state_q    <= CLEAR;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign pe_en         = pe_en_q;
  assign pe_reset      = pe_reset_q;
  assign pe_acc        = pe_acc_q;
  assign pe_data_valid = in_ready_q && in_valid;
  assign pe_weight     = pe_data_valid ? in_weight : '0;
  assign pe_act        = pe_data_valid ? in_act : '0;

  pe_result_slot #(
    .CNT_W(CNT_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (slot_load),
    .data_i     (pe_output_result),
    .count_i    (cnt_q),
    .out_ready_i(out_ready),
    .free_o     (slot_free),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_count_o(out_count)
  );

endmodule

// File: tb/tb_pe_stream_feeder.sv
// tb/tb_pe_stream_feeder.sv - directed scoreboard bench for pe_stream_feeder with a behavioural PE
module tb_pe_stream_feeder;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [3:0]  in_weight;
  logic signed [7:0]  in_act;
  logic               in_last;
  logic               pe_en;
  logic               pe_data_valid;
  logic signed [3:0]  pe_weight;
  logic signed [7:0]  pe_act;
  logic               pe_acc;
  logic               pe_reset;
  logic               pe_output_valid;
  logic signed [20:0] pe_output_result;
  logic               out_valid;
  logic               out_ready;
  logic signed [20:0] out_data;
  logic [6:0]         out_count;

  pe_stream_feeder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_weight       (in_weight),
    .in_act          (in_act),
    .in_last         (in_last),
    .pe_en           (pe_en),
    .pe_data_valid   (pe_data_valid),
    .pe_weight       (pe_weight),
    .pe_act          (pe_act),
    .pe_acc          (pe_acc),
    .pe_reset        (pe_reset),
    .pe_output_valid (pe_output_valid),
    .pe_output_result(pe_output_result),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_count       (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PE: accumulates while streaming, result valid 8 cycles after the acc pulse.
  logic signed [20:0] pe_sum;
  logic [3:0]         pe_dcnt;
  logic signed [20:0] w_ext;
  logic signed [20:0] a_ext;
  assign w_ext = 21'(pe_weight);
  assign a_ext = 21'(pe_act);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_sum           <= '0;
      pe_dcnt          <= '0;
      pe_output_valid  <= 1'b0;
      pe_output_result <= '0;
    end else if (pe_reset) begin
      pe_sum           <= '0;
      pe_dcnt          <= '0;
      pe_output_valid  <= 1'b0;
      pe_output_result <= '0;
    end else begin
      if (pe_data_valid) pe_sum <= pe_sum + w_ext * a_ext;
      if (pe_acc) begin
        pe_dcnt <= 4'd7;
      end else if (pe_dcnt != 4'd0) begin
        pe_dcnt <= pe_dcnt - 4'd1;
        if (pe_dcnt == 4'd1) begin
          pe_output_valid  <= 1'b1;
          pe_output_result <= pe_sum;
        end
      end
    end
  end

  typedef struct {
    int data;
    int count;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   e_sum;
  int   e_cnt;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("pin_invariant",
          ((int'(pe_reset) + int'(pe_acc) + int'(pe_data_valid)) <= 1) && (!pe_data_valid || in_ready),
          1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", $signed(out_data), e.data);
          chk("out_count", out_count, e.count);
        end
      end
    end
  end

  task automatic vec_begin();
    e_sum = 0;
    e_cnt = 0;
  endtask

  task automatic vec_push();
    exp_t e;
    e.data  = e_sum;
    e.count = e_cnt;
    sb.push_back(e);
  endtask

  task automatic send_beat(input int w, input int a, input bit last, output int acc_cyc);
    bit got_it;
    got_it    = 1'b0;
    in_valid  = 1'b1;
    in_weight = 4'(w);
    in_act    = 8'(a);
    in_last   = last;
    for (int k = 0; k < 400; k++) begin
      if (in_ready) begin
        got_it = 1'b1;
        break;
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    if (!got_it) chk("accept_timeout", got_it, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    e_sum += w * a;
    e_cnt++;
  endtask

  task automatic wait_out(input int c0, input string tag);
    for (int k = 0; k < 60; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk(tag, cyc - c0, 10);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain_timeout", ok, 1);
  endtask

  initial begin
    int c;
    int c0;
    int c64;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_weight = '0;
    in_act    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_ctrl", {in_ready, pe_en, pe_data_valid, pe_acc, out_valid}, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_pe_data", {pe_weight, pe_act}, 0);
    rst_n = 1'b1;
    #1;
    chk("clear_pe_reset", pe_reset, 1);
    @(negedge clk);
    chk("post_rst_en_ready", {pe_en, in_ready, pe_reset}, 3'b110);

    // Basic dot product
    vec_begin();
    send_beat(1, 10, 0, c);
    send_beat(2, 5, 0, c);
    send_beat(-3, 4, 0, c);
    send_beat(0, 99, 1, c0);
    vec_push();
    chk("basic_expect", e_sum, 8);
    wait_out(c0, "basic_latency");
    wait_drain();

    // Full-length vector terminates on count, next beat waits for STREAM
    vec_begin();
    for (int i = 0; i < 64; i++) send_beat(7, 127, 0, c64);
    vec_push();
    in_valid  = 1'b1;
    in_weight = 4'sd3;
    in_act    = -8'sd2;
    in_last   = 1'b1;
    #1;
    chk("held_ready", {in_ready, pe_data_valid}, 0);
    chk("held_gated", {pe_weight, pe_act}, 0);
    @(negedge clk);
    vec_begin();
    send_beat(3, -2, 1, c);
    vec_push();
    chk("beat65_held", c - c64, 11);
    wait_drain();

    // Output backpressure: first result parked, second vector held in CAPTURE
    out_ready = 1'b0;
    vec_begin();
    send_beat(4, -5, 0, c);
    send_beat(-6, 7, 1, c);
    vec_push();
    vec_begin();
    send_beat(3, 3, 0, c);
    send_beat(-1, 100, 0, c);
    send_beat(2, -50, 1, c0);
    vec_push();
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("bp_ctrl", {out_valid, pe_reset, in_ready}, 3'b100);
      chk("bp_data", $signed(out_data), -62);
      @(negedge clk);
    end
    out_ready = 1'b1;
    vec_begin();
    send_beat(1, -1, 0, c);
    send_beat(5, 20, 1, c);
    vec_push();
    wait_drain();

    // Input bubbles across three back-to-back vectors
    for (int v = 0; v < 3; v++) begin
      vec_begin();
      n = 3 + 2 * v;
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_beat(int'($urandom_range(0, 14)) - 7, int'($urandom_range(0, 255)) - 128, (j == n - 1), c);
      end
      vec_push();
    end
    wait_drain();

    // Reset in the middle of the drain aborts the vector
    vec_begin();
    send_beat(2, 3, 0, c);
    send_beat(4, 4, 1, c0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {in_ready, pe_en, pe_data_valid, pe_acc, out_valid}, 0);
    chk("midrst_out_data", $signed(out_data), 0);
    chk("midrst_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_begin();
    send_beat(-7, -128, 1, c0);
    vec_push();
    chk("midrst_expect", e_sum, 896);
    wait_out(c0, "midrst_latency");
    wait_drain();

    // Single-beat vector
    vec_begin();
    send_beat(5, -3, 1, c0);
    vec_push();
    chk("single_expect", e_sum, -15);
    wait_out(c0, "single_latency");
    wait_drain();

    chk("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
